// File: rtl/booth_div.sv
// Sequential signed divider for the multiply/divide unit.
// Restoring shift-subtract on operand magnitudes, one quotient bit per clock,
// followed by a sign fix-up. Quotient truncates toward zero, remainder takes
// the sign of the dividend. Divide-by-zero skips the iterations and leaves
// the previous results in place.
//
// Handshake: divCtrl is a start request honoured only while busy is low; the
// operands are captured on that edge. divEnd is a one-cycle completion pulse,
// and divZero is valid with it and held until the next accepted start.
module booth_div #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              divCtrl,
  input  logic [DATA_W-1:0] valueA,
  input  logic [DATA_W-1:0] valueB,
  output logic [DATA_W-1:0] mostSig,
  output logic [DATA_W-1:0] leastSig,
  output logic              divEnd,
  output logic              divZero,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              sign_a_q, sign_a_d;
  logic              neg_q_q, neg_q_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              end_q, end_d;
  logic              zero_q, zero_d;

  // Shifted partial remainder and trial subtraction, one bit wider than data.
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;

  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_a_q <= 1'b0;
      neg_q_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      end_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign_a_q <= sign_a_d;
      neg_q_q  <= neg_q_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      end_q    <= end_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state and datapath: capture, iterate, fix signs, then one idle-bound cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign_a_d = sign_a_q;
    neg_q_d  = neg_q_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    end_d    = 1'b0;
    zero_d   = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (divCtrl) begin
          // Magnitudes are taken modulo 2^DATA_W, so the most negative value maps to itself.
          quo_d    = valueA[DATA_W-1] ? (-valueA) : valueA;
          dvs_d    = valueB[DATA_W-1] ? (-valueB) : valueB;
          sign_a_d = valueA[DATA_W-1];
          neg_q_d  = valueA[DATA_W-1] ^ valueB[DATA_W-1];
          rem_d    = '0;
          cnt_d    = '0;
          if (valueB == '0) begin
            zero_d  = 1'b1;
            end_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!trial[DATA_W]) begin
          rem_d = trial[DATA_W-1:0];
        end else begin
          rem_d = shifted[DATA_W-1:0];
        end
        quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        lo_d    = neg_q_q  ? (-quo_q) : quo_q;
        hi_d    = sign_a_q ? (-rem_q) : rem_q;
        end_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mostSig     = hi_q;
  assign leastSig    = lo_q;
  assign divEnd      = end_q;
  assign divZero     = zero_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_div.sv
// Testbench for booth_div: directed corner cases plus randomized operands,
// checked against a 64-bit signed arithmetic reference model.
module tb_booth_div;

  localparam int W  = 32;
  localparam int EW = 2 * W + 1;

  logic          clock;
  logic          reset;
  logic          divCtrl;
  logic [W-1:0]  valueA;
  logic [W-1:0]  valueB;
  logic [W-1:0]  mostSig;
  logic [W-1:0]  leastSig;
  logic          divEnd;
  logic          divZero;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  // Scoreboard entries are {divZero, HI, LO}.
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  last_hi = '0;
  logic [W-1:0]  last_lo = '0;

  booth_div #(.DATA_W(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .divCtrl     (divCtrl),
    .valueA      (valueA),
    .valueB      (valueB),
    .mostSig     (mostSig),
    .leastSig    (leastSig),
    .divEnd      (divEnd),
    .divZero     (divZero),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock and edge counter.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: MIPS DIV semantics from wide signed arithmetic; zero divisor keeps old results.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return {1'b1, last_hi, last_lo};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [EW-1:0] e;
    e = model(a, b);
    exp_q.push_back(e);
    last_hi = e[2*W-1:W];
    last_lo = e[W-1:0];
  endtask

  // Driver: one-cycle start pulse; returns #1 after the start edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    valueA  = a;
    valueB  = b;
    divCtrl = 1'b1;
    @(posedge clock);
    #1;
    t0      = cyc;
    divCtrl = 1'b0;
    push_exp(a, b);
  endtask

  // Waits (bounded) for divEnd, checks latency and results, then the return to idle.
  task automatic finish_op(input string tag, input int exp_lat);
    int n;
    logic [EW-1:0] e;
    n = 0;
    while (divEnd !== 1'b1 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (divEnd !== 1'b1) begin
      check({tag, "_timeout"}, 64'(divEnd), 64'd1);
      return;
    end
    check({tag, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_lo"},   64'(leastSig), 64'(e[W-1:0]));
    check({tag, "_hi"},   64'(mostSig),  64'(e[2*W-1:W]));
    check({tag, "_zero"}, 64'(divZero),  64'(e[2*W]));
    @(posedge clock);
    #1;
    check({tag, "_pulse"}, 64'(divEnd), 64'd0);
    check({tag, "_idle"},  64'(busy),   64'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(a, b);
    finish_op(tag, (b == '0) ? 0 : 33);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hi"},   64'(mostSig),  64'd0);
    check({tag, "_lo"},   64'(leastSig), 64'd0);
    check({tag, "_end"},  64'(divEnd),   64'd0);
    check({tag, "_zero"}, 64'(divZero),  64'd0);
    check({tag, "_busy"}, 64'(busy),     64'd0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      4:       return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int ends_seen;
    logic [W-1:0] a, b;
    reset   = 1'b1;
    divCtrl = 1'b0;
    valueA  = '0;
    valueB  = '0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst_init");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_reset_outputs("rst_release");

    // Sign combinations.
    run_op("p100_p7", 32'd100, 32'd7);
    check("p100_p7_lo_lit", 64'(leastSig), 64'h0000_000E);
    check("p100_p7_hi_lit", 64'(mostSig),  64'h0000_0002);
    run_op("n100_p7", -32'd100, 32'd7);
    check("n100_p7_lo_lit", 64'(leastSig), 64'hFFFF_FFF2);
    check("n100_p7_hi_lit", 64'(mostSig),  64'hFFFF_FFFE);
    run_op("p100_n7", 32'd100, -32'd7);
    check("p100_n7_hi_lit", 64'(mostSig),  64'h0000_0002);
    run_op("n100_n7", -32'd100, -32'd7);
    check("n100_n7_lo_lit", 64'(leastSig), 64'h0000_000E);

    // Divide by zero keeps the previous results; the next start clears the flag.
    run_op("p100_p7b", 32'd100, 32'd7);
    run_op("div0", 32'd5, 32'd0);
    check("div0_hi_lit", 64'(mostSig),  64'd2);
    check("div0_lo_lit", 64'(leastSig), 64'd14);
    check("div0_flag_held", 64'(divZero), 64'd1);
    run_op("after_div0", 32'd9, 32'd3);

    // Overflow and most-negative dividend.
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lo_lit", 64'(leastSig), 64'h8000_0000);
    check("ovf_hi_lit", 64'(mostSig),  64'd0);
    run_op("minneg_1", 32'h8000_0000, 32'd1);

    // Reset in the middle of an operation.
    start_op(32'd100, 32'd7);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    exp_q.delete();
    last_hi = '0;
    last_lo = '0;
    @(negedge clock);
    reset = 1'b0;
    ends_seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (divEnd === 1'b1) ends_seen++;
    end
    check("rst_mid_no_end", 64'(ends_seen), 64'd0);
    run_op("after_rst", 32'd9, 32'd3);

    // Start requests and operand changes while busy are ignored.
    start_op(32'd100, 32'd7);
    repeat (20) begin
      @(negedge clock);
      divCtrl = 1'($urandom);
      valueA  = $urandom;
      valueB  = $urandom;
    end
    @(negedge clock);
    divCtrl = 1'b0;
    finish_op("busy_ign", 33);
    check("busy_ign_lo_lit", 64'(leastSig), 64'd14);

    // Back-to-back: divCtrl held high restarts on the first idle edge.
    @(negedge clock);
    valueA  = 32'd100;
    valueB  = 32'd7;
    divCtrl = 1'b1;
    @(posedge clock);
    #1;
    t0 = cyc;
    push_exp(32'd100, 32'd7);
    valueA = 32'd9;
    valueB = 32'd3;
    push_exp(32'd9, 32'd3);
    finish_op("b2b_first", 33);
    finish_op("b2b_second", 68);
    divCtrl = 1'b0;

    // Randomized operands.
    for (int i = 0; i < 40; i++) begin
      a = rand_operand();
      b = ($urandom_range(0, 7) == 0) ? '0 : rand_operand();
      run_op("rand", a, b);
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
